// File: rtl/s1269_seq_pkg.sv
// Shared types for the op sequencer: FSM state encoding, default widths and the
// datapath load/store strobe bundle.
package s1269_seq_pkg;

  localparam int unsigned DefaultDpW  = 8;
  localparam int unsigned DefaultInsW = 3;

  typedef enum logic [3:0] {
    StRst,
    StIdle,
    StLoadDr,
    StLoadMq,
    StClrAcc,
    StIssue,
    StWaitRdy,
    StReadAcc,
    StReadMq,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic ld_dr;
    logic ld_mq;
    logic ld_acc;
    logic st_acc;
    logic st_mq;
    logic st_dr;
  } strobe_t;

  localparam strobe_t StrobeIdle = '0;

endpackage

// File: rtl/s1269_op_sequencer_if.sv
// Command, response and datapath signals of the op sequencer. The slave side is the
// sequencer; the master side is the host plus the datapath it drives.
interface s1269_op_sequencer_if
  import s1269_seq_pkg::*;
#(
  parameter int unsigned DP_W  = DefaultDpW,
  parameter int unsigned INS_W = DefaultInsW
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [INS_W-1:0] cmd_op;
  logic [DP_W-1:0]  cmd_a;
  logic [DP_W-1:0]  cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DP_W-1:0]  rsp_hi;
  logic [DP_W-1:0]  rsp_lo;
  logic             rsp_err;

  logic [INS_W-1:0] dp_INS;
  logic             dp_LDDR;
  logic             dp_LDMQ;
  logic             dp_LDAcc;
  logic             dp_STAcc;
  logic             dp_STMQ;
  logic             dp_STDR;
  logic             dp_TESTMODE;
  logic [DP_W-1:0]  dp_inBUS;
  logic [DP_W-1:0]  dp_outBUS;
  logic             dp_RDY;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, dp_outBUS, dp_RDY,
    output cmd_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
    output dp_INS, dp_LDDR, dp_LDMQ, dp_LDAcc, dp_STAcc, dp_STMQ, dp_STDR,
    output dp_TESTMODE, dp_inBUS
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, dp_outBUS, dp_RDY,
    input  cmd_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
    input  dp_INS, dp_LDDR, dp_LDMQ, dp_LDAcc, dp_STAcc, dp_STMQ, dp_STDR,
    input  dp_TESTMODE, dp_inBUS
  );

endinterface

// File: rtl/s1269_wait_timer.sv
// Saturating wait counter for the RDY poll; expired flags the last permitted
// not-ready sample.
module s1269_wait_timer #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CntMax)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign expired = (count_q == CntLast);

endmodule

// File: rtl/s1269_op_sequencer.sv
// Sequences one ALU operation at a time: load DR/MQ, clear Acc, issue INS, wait for
// RDY (with timeout), read Acc and MQ back, then hold the response until taken.
module s1269_op_sequencer
  import s1269_seq_pkg::*;
#(
  parameter int unsigned DP_W    = DefaultDpW,
  parameter int unsigned INS_W   = DefaultInsW,
  parameter int unsigned TIMEOUT = 63
) (
  input logic                 clock,
  input logic                 reset,
  s1269_op_sequencer_if.slave bus
);

  seq_state_e       state_q;
  strobe_t          strobe_q;
  logic [DP_W-1:0]  inbus_q;
  logic [INS_W-1:0] ins_q;
  logic [INS_W-1:0] op_q;
  logic [DP_W-1:0]  a_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [DP_W-1:0]  rsp_hi_q;
  logic [DP_W-1:0]  rsp_lo_q;
  logic             rsp_err_q;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign timer_clear  = (state_q == StIssue);
  assign timer_enable = (state_q == StWaitRdy) && !bus.dp_RDY;

  s1269_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Strobes and inBUS default to idle every cycle so only one state can raise them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRst;
      strobe_q    <= StrobeIdle;
      inbus_q     <= '0;
      ins_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      strobe_q <= StrobeIdle;
      inbus_q  <= '0;
      unique case (state_q)
        StRst: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q           <= bus.cmd_op;
            a_q            <= bus.cmd_a;
            cmd_ready_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            strobe_q.ld_dr <= 1'b1;
            inbus_q        <= bus.cmd_b;
            state_q        <= StLoadDr;
          end
        end
        StLoadDr: begin
          strobe_q.ld_mq <= 1'b1;
          inbus_q        <= a_q;
          state_q        <= StLoadMq;
        end
        StLoadMq: begin
          strobe_q.ld_acc <= 1'b1;
          state_q         <= StClrAcc;
        end
        StClrAcc: begin
          ins_q   <= op_q;
          state_q <= StIssue;
        end
        StIssue: begin
          state_q <= StWaitRdy;
        end
        StWaitRdy: begin
          // RDY has priority over a timeout landing on the same edge.
          if (bus.dp_RDY || timer_expired) begin
            rsp_err_q       <= !bus.dp_RDY;
            ins_q           <= '0;
            strobe_q.st_acc <= 1'b1;
            state_q         <= StReadAcc;
          end
        end
        StReadAcc: begin
          rsp_hi_q       <= bus.dp_outBUS;
          strobe_q.st_mq <= 1'b1;
          state_q        <= StReadMq;
        end
        StReadMq: begin
          rsp_lo_q    <= bus.dp_outBUS;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StRst;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hi      = rsp_hi_q;
  assign bus.rsp_lo      = rsp_lo_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.dp_INS      = ins_q;
  assign bus.dp_LDDR     = strobe_q.ld_dr;
  assign bus.dp_LDMQ     = strobe_q.ld_mq;
  assign bus.dp_LDAcc    = strobe_q.ld_acc;
  assign bus.dp_STAcc    = strobe_q.st_acc;
  assign bus.dp_STMQ     = strobe_q.st_mq;
  assign bus.dp_STDR     = strobe_q.st_dr;
  assign bus.dp_TESTMODE = 1'b0;
  assign bus.dp_inBUS    = inbus_q;

endmodule

// File: tb/tb_s1269_op_sequencer.sv
// Scoreboard bench for s1269_op_sequencer with a datapath model (RDY delay, outBUS
// readback) and a per-cycle strobe invariant monitor.
module tb_s1269_op_sequencer;

  localparam int unsigned TIMEOUT = 63;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic clock;
  logic reset;
  s1269_op_sequencer_if bus ();

  s1269_op_sequencer #(
    .DP_W    (8),
    .INS_W   (3),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  int         rdy_low = 0;
  int         ins_cycles = 0;
  logic [7:0] acc_val = 8'h00;
  logic [7:0] mq_val = 8'h00;
  int         hs_cyc = 0;
  logic       hold_next = 1'b0;
  logic [2:0] next_op = 3'b000;
  logic [7:0] next_a = 8'h00;
  logic [7:0] next_b = 8'h00;

  logic [17:0] trace;
  logic [36:0] outs_all;
  assign trace = {bus.rsp_valid, bus.dp_INS, bus.dp_LDDR, bus.dp_LDMQ, bus.dp_LDAcc,
                  bus.dp_STAcc, bus.dp_STMQ, bus.dp_STDR, bus.dp_inBUS};
  assign outs_all = {bus.cmd_ready, trace, bus.rsp_hi, bus.rsp_lo, bus.rsp_err,
                     bus.dp_TESTMODE};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath model: RDY rises after rdy_low not-ready samples in WAIT_RDY.
  assign bus.dp_outBUS = bus.dp_STAcc ? acc_val : (bus.dp_STMQ ? mq_val : 8'h00);
  always @(negedge clock) begin
    if (bus.dp_INS != 3'b000) ins_cycles = ins_cycles + 1;
    else ins_cycles = 0;
    bus.dp_RDY = (ins_cycles > rdy_low + 1);
  end

  always @(negedge clock) begin
    if (!reset) begin
      vectors = vectors + 1;
      if (($countones({bus.dp_LDDR, bus.dp_LDMQ, bus.dp_LDAcc}) > 1) ||
          ($countones({bus.dp_STAcc, bus.dp_STMQ, bus.dp_STDR}) > 1) ||
          ((bus.dp_LDDR | bus.dp_LDMQ | bus.dp_LDAcc) &&
           (bus.dp_STAcc | bus.dp_STMQ | bus.dp_STDR)) ||
          bus.dp_STDR || bus.dp_TESTMODE ||
          (!(bus.dp_LDDR | bus.dp_LDMQ | bus.dp_LDAcc) && (bus.dp_inBUS != 8'h00))) begin
        miscompares = miscompares + 1;
        $display("FAIL invariant cyc=%0d: strobes/inBUS %h, required legal pattern",
                 cyc, trace);
      end
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] acc, input logic [7:0] mq, input int low);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clock);
    while (!bus.cmd_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_wait: cmd_ready=0 after %0d cycles, required 1", waited);
      return;
    end
    rdy_low = low;
    acc_val = acc;
    mq_val = mq;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    @(posedge clock);
    #1;
    e.op = op;
    e.a = a;
    e.b = b;
    e.hi = acc;
    e.lo = mq;
    e.err = (low >= int'(TIMEOUT));
    e.lat = e.err ? 7 + int'(TIMEOUT) : 8 + low;
    e.acc_cyc = cyc;
    sb.push_back(e);
    // Operands must be latched: scramble the inputs once accepted.
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'b000;
    bus.cmd_a = ~a;
    bus.cmd_b = ~b;
  endtask

  task automatic recv_rsp(input int rsp_delay);
    exp_t        e;
    logic [17:0] exp_tr;
    int          n;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL recv_empty: no command outstanding, required one");
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (n < e.lat) begin
      @(negedge clock);
      n = cyc - e.acc_cyc + 1;
      exp_tr = '0;
      if (n == 1) exp_tr = {1'b0, 3'b000, 6'b100000, e.b};
      else if (n == 2) exp_tr = {1'b0, 3'b000, 6'b010000, e.a};
      else if (n == 3) exp_tr = {1'b0, 3'b000, 6'b001000, 8'h00};
      else if (n <= e.lat - 3) exp_tr = {1'b0, e.op, 6'b000000, 8'h00};
      else if (n == e.lat - 2) exp_tr = {1'b0, 3'b000, 6'b000100, 8'h00};
      else if (n == e.lat - 1) exp_tr = {1'b0, 3'b000, 6'b000010, 8'h00};
      else exp_tr = {1'b1, 3'b000, 6'b000000, 8'h00};
      vectors++;
      if (trace !== exp_tr) begin
        miscompares++;
        $display("FAIL trace T+%0d: got %h, required %h", n, trace, exp_tr);
      end
    end
    vectors++;
    if ({bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {e.hi, e.lo, e.err}) begin
      miscompares++;
      $display("FAIL rsp_data: got hi=%h lo=%h err=%b, required hi=%h lo=%h err=%b",
               bus.rsp_hi, bus.rsp_lo, bus.rsp_err, e.hi, e.lo, e.err);
    end
    if (hold_next) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = next_op;
      bus.cmd_a = next_a;
      bus.cmd_b = next_b;
    end
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clock);
      vectors++;
      if ({bus.cmd_ready, trace, bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !==
          {1'b0, 18'h20000, e.hi, e.lo, e.err}) begin
        miscompares++;
        $display("FAIL rsp_hold %0d: got rdy=%b tr=%h hi=%h lo=%h err=%b, required held",
                 i, bus.cmd_ready, trace, bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    hs_cyc = cyc;
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL handshake: got valid=%b cmd_ready=%b, required 0 1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (outs_all !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs_all);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b, required 0", bus.cmd_ready);
    end
    @(posedge clock);
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_idle: got ready=%b valid=%b, required 1 0",
               bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_basic();
    send_cmd(3'b010, 8'h0F, 8'h03, 8'h2D, 8'h01, 0);
    recv_rsp(0);
  endtask

  task automatic test_rdy_delay();
    send_cmd(3'b010, 8'h5C, 8'hC3, 8'h9E, 8'h44, 10);
    recv_rsp(1);
  endtask

  task automatic test_timeout();
    send_cmd(3'b010, 8'h01, 8'h02, 8'hE1, 8'h7B, 255);
    recv_rsp(0);
    send_cmd(3'b111, 8'hAA, 8'h55, 8'h3C, 8'hC3, int'(TIMEOUT) - 1);
    recv_rsp(0);
    send_cmd(3'b001, 8'h80, 8'h08, 8'h12, 8'h34, int'(TIMEOUT));
    recv_rsp(0);
  endtask

  task automatic test_backpressure();
    send_cmd(3'b101, 8'h11, 8'h22, 8'hA5, 8'h5A, 2);
    hold_next = 1'b1;
    next_op = 3'b011;
    next_a = 8'h44;
    next_b = 8'h66;
    recv_rsp(5);
    hold_next = 1'b0;
    send_cmd(3'b011, 8'h44, 8'h66, 8'h77, 8'h88, 0);
    vectors++;
    if (sb.size() == 0 || sb[0].acc_cyc != hs_cyc + 1) begin
      miscompares++;
      $display("FAIL back_to_back: accept after handshake at %0d, required %0d",
               (sb.size() == 0) ? -1 : sb[0].acc_cyc, hs_cyc + 1);
    end
    recv_rsp(0);
  endtask

  task automatic test_reset_mid();
    send_cmd(3'b110, 8'h12, 8'h34, 8'hFF, 8'hFF, 255);
    repeat (8) @(negedge clock);
    vectors++;
    if (bus.dp_INS !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_wait_ins: got %b, required 110", bus.dp_INS);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (outs_all !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %h, required 0", outs_all);
    end
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.dp_INS} !== 5'b10000) begin
      miscompares++;
      $display("FAIL mid_restart: got ready=%b valid=%b ins=%b, required 1 0 000",
               bus.cmd_ready, bus.rsp_valid, bus.dp_INS);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b, acc, mq;
    int         sel, low;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(7, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      acc = 8'($urandom);
      mq = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 6) low = sel;
      else if (sel == 6) low = int'(TIMEOUT) - 1;
      else if (sel == 7) low = int'(TIMEOUT);
      else low = 20 + sel;
      send_cmd(op, a, b, acc, mq, low);
      recv_rsp(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'b000;
    bus.cmd_a = 8'h00;
    bus.cmd_b = 8'h00;
    bus.rsp_ready = 1'b0;
    bus.dp_RDY = 1'b0;
    test_reset();
    test_basic();
    test_rdy_delay();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
